prn_data_convert_mc: RTL

- Parametrised, multi-channel successor to the fixed 4-lane print-data converter.
- Accepts packed host words, reorders bits into per-channel lanes using a selectable mode, and stores one print line per bank in a ping-pong buffer.
- Lets the print-head side read the previous line while the next one is written.
- Sits between the host/DDR line fetch and the print-head shift logic; adds channel masking, line-length checking and classified sticky errors.

---
 rtl/prn_cvt_pkg.sv | 39 +++
 rtl/prn_lane_buf.sv | 48 ++++
 rtl/prn_data_convert_mc.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prn_cvt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_cvt_pkg                                                  |
// | Description : Shared constants and the lane bit-mapping function for the   |
// |               multi-channel print-data converter.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package prn_cvt_pkg;

    // Bit-order modes; encoding 3 is reserved and treated as straight.
    localparam logic [1:0] MODE_INTLV    = 2'd0;
    localparam logic [1:0] MODE_STRAIGHT = 2'd1;
    localparam logic [1:0] MODE_REV      = 2'd2;

    // Sticky error flag positions.
    localparam int ERR_OVF    = 0;
    localparam int ERR_UDF    = 1;
    localparam int ERR_LEN    = 2;
    localparam int ERR_UNREAD = 3;
    localparam int NUM_ERR    = 4;

    // Returns the host-word bit index that feeds bit b of lane c.
    // Interleaved: the low half of each lane comes from the low half of the
    // word, the high half of the lane from the matching slot in the high half.
    function automatic int lane_src_idx(input logic [1:0] m, input int nch,
                                        input int bpc, input int c, input int b);
        int hb;
        int hw;
        hb = bpc / 2;
        hw = (nch * bpc) / 2;
        case (m)
            MODE_INTLV: lane_src_idx = (b < hb) ? (c * hb + b) : (hw + c * hb + (b - hb));
            MODE_REV:   lane_src_idx = c * bpc + (bpc - 1 - b);
            default:    lane_src_idx = c * bpc + b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/prn_lane_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_lane_buf                                                 |
// | Description : Single-channel ping-pong line buffer. Simple dual-port RAM   |
// |               of two banks, address {bank, ptr}, registered read port      |
// |               that can also be forced to zero (masked channel/underflow).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module prn_lane_buf #(
    parameter int BITS = 4,
    parameter int AW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic [AW:0]     i_wr_addr,
    input  logic [BITS-1:0] i_wr_data,
    input  logic            i_rd_en,
    input  logic            i_rd_zero,
    input  logic [AW:0]     i_rd_addr,
    output logic [BITS-1:0] o_rd_data
);

    logic [BITS-1:0] r_mem [0:(2**(AW+1))-1];
    logic [BITS-1:0] r_rd_data;

    // Write port: storage array carries no reset, contents are gated by pointers.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: holds its value between reads, zero-loaded when masked or empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_zero) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/prn_data_convert_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_data_convert_mc                                          |
// | Description : Multi-channel print-data converter. Remaps host words into   |
// |               per-channel lanes, buffers one line per bank (ping-pong),    |
// |               and serves the previous line to the print-head side with     |
// |               channel masking, line-length checks and sticky errors.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module prn_data_convert_mc
    import prn_cvt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int BITS_PER_CH = 4,
    parameter int DEPTH       = 256,
    parameter int DW          = NUM_CH * BITS_PER_CH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_switch,
    input  logic [1:0]        mode,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [AW:0]       line_len,
    input  logic              wr_req,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_req,
    output logic [DW-1:0]     prn_data,
    output logic              prn_valid,
    output logic              rd_empty,
    input  logic              err_clr,
    output logic [3:0]        err_flags,
    output logic              data_error
);

    localparam int DIW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic               r_wr_bank;
    logic [AW:0]        r_wr_cnt;
    logic [AW:0]        r_rd_ptr;
    logic [AW:0]        r_rd_len;
    logic [1:0]         r_mode_act;
    logic               r_started;
    logic               r_prn_valid;
    logic               r_rd_empty;
    logic [NUM_ERR-1:0] r_err;

    logic               w_wr_accept;
    logic               w_rd_accept;
    logic [AW:0]        w_wr_cnt_inc;
    logic [AW:0]        w_rd_ptr_inc;
    logic [AW:0]        w_wr_cnt_nxt;
    logic [AW:0]        w_rd_ptr_nxt;
    logic [AW:0]        w_rd_len_nxt;
    logic [NUM_ERR-1:0] w_err_set;
    logic [AW:0]        w_wr_addr;
    logic [AW:0]        w_rd_addr;

    // Pointer arithmetic, swap behaviour and error detection for this cycle.
    // A write or read coinciding with the swap is counted before the swap.
    always_comb begin
        w_wr_accept  = wr_req & (r_wr_cnt != c_depth);
        w_rd_accept  = rd_req & (r_rd_ptr != r_rd_len);
        w_wr_cnt_inc = w_wr_accept ? r_wr_cnt + 1'b1 : r_wr_cnt;
        w_rd_ptr_inc = w_rd_accept ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_wr_cnt_nxt = w_wr_cnt_inc;
        w_rd_ptr_nxt = w_rd_ptr_inc;
        w_rd_len_nxt = r_rd_len;
        w_err_set    = '0;
        w_err_set[ERR_OVF] = wr_req & ~w_wr_accept;
        w_err_set[ERR_UDF] = rd_req & ~w_rd_accept;
        if (data_switch) begin
            w_err_set[ERR_LEN]    = (line_len != '0) && (w_wr_cnt_inc != line_len);
            w_err_set[ERR_UNREAD] = (w_rd_ptr_inc != r_rd_len);
            w_wr_cnt_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_rd_len_nxt = w_wr_cnt_inc;
        end
    end

    // Control state: bank select, pointers, mode latch, read status and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_rd_len    <= '0;
            r_mode_act  <= MODE_INTLV;
            r_started   <= 1'b0;
            r_prn_valid <= 1'b0;
            r_rd_empty  <= 1'b1;
            r_err       <= '0;
        end else begin
            r_started   <= 1'b1;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_rd_len    <= w_rd_len_nxt;
            r_prn_valid <= w_rd_accept;
            r_rd_empty  <= (w_rd_ptr_nxt == w_rd_len_nxt);
            r_err       <= (err_clr ? '0 : r_err) | w_err_set;
            if (data_switch) begin
                r_wr_bank <= ~r_wr_bank;
            end
            // Mode is captured on the first clock after reset and at each swap.
            if (!r_started || data_switch) begin
                r_mode_act <= mode;
            end
        end
    end

    assign w_wr_addr = {r_wr_bank, r_wr_cnt[AW-1:0]};
    assign w_rd_addr = {~r_wr_bank, r_rd_ptr[AW-1:0]};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [BITS_PER_CH-1:0] w_lane;

            for (genvar b = 0; b < BITS_PER_CH; b++) begin : g_bit
                assign w_lane[b] =
                    wr_data[DIW'(lane_src_idx(r_mode_act, NUM_CH, BITS_PER_CH, c, b))];
            end

            prn_lane_buf #(
                .BITS (BITS_PER_CH),
                .AW   (AW)
            ) u_lane_buf (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (w_wr_accept),
                .i_wr_addr (w_wr_addr),
                .i_wr_data (w_lane),
                .i_rd_en   (w_rd_accept & ch_en[c]),
                .i_rd_zero ((w_rd_accept & ~ch_en[c]) | (rd_req & ~w_rd_accept)),
                .i_rd_addr (w_rd_addr),
                .o_rd_data (prn_data[c*BITS_PER_CH +: BITS_PER_CH])
            );
        end
    endgenerate

    assign prn_valid  = r_prn_valid;
    assign rd_empty   = r_rd_empty;
    assign err_flags  = r_err;
    assign data_error = |r_err;

endmodule
`default_nettype wire
